// File: rtl/soc_miner_dma.sv
// soc_miner_dma: store-and-forward AXI4 copy engine for the soc_miner memory port.
// A Go pulse in IDLE copies Length bytes (multiple of 8) from a source to a
// destination address. Each burst is one AR/R read into a local buffer, then
// one AW/W/B write draining it. Bursts never cross a 4 KB boundary.
//
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Go                    start pulse (ignored unless idle)
//   Src_addr, Dst_addr    30-bit word addresses; byte address = {addr, 2'b00}, addr[0] forced 0
//   Length                byte count, bits [2:0] ignored
//   Busy, Done, Error     status: not idle, end-of-copy pulse, sticky error
//   m_memory_ar*/r*       AXI4 read address / read data channels
//   m_memory_aw*/w*/b*    AXI4 write address / write data / write response channels

module soc_miner_dma #(
    parameter int MEMORY_DATA_WIDTH    = 64,
    parameter int MEMORY_ADDR_WIDTH    = 32,
    parameter int MEMORY_BUS_LEN_WIDTH = 4,
    parameter int MEMORY_ID_WIDTH      = 6,
    parameter int MAX_BURST            = 16,
    parameter int AXI_ID               = 0
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic                            Go,
    input  logic [29:0]                     Src_addr,
    input  logic [29:0]                     Dst_addr,
    input  logic [31:0]                     Length,
    output logic                            Busy,
    output logic                            Done,
    output logic                            Error,
    output logic                            m_memory_arvalid,
    input  logic                            m_memory_arready,
    output logic [MEMORY_ADDR_WIDTH-1:0]    m_memory_araddr,
    output logic [MEMORY_BUS_LEN_WIDTH-1:0] m_memory_arlen,
    output logic [MEMORY_ID_WIDTH-1:0]      m_memory_arid,
    output logic [2:0]                      m_memory_arsize,
    output logic [1:0]                      m_memory_arburst,
    output logic [1:0]                      m_memory_arlock,
    output logic [3:0]                      m_memory_arcache,
    output logic [2:0]                      m_memory_arprot,
    output logic [3:0]                      m_memory_arqos,
    input  logic                            m_memory_rvalid,
    output logic                            m_memory_rready,
    input  logic [MEMORY_DATA_WIDTH-1:0]    m_memory_rdata,
    input  logic                            m_memory_rlast,
    input  logic [1:0]                      m_memory_rresp,
    input  logic [MEMORY_ID_WIDTH-1:0]      m_memory_rid,
    output logic                            m_memory_awvalid,
    input  logic                            m_memory_awready,
    output logic [MEMORY_ADDR_WIDTH-1:0]    m_memory_awaddr,
    output logic [MEMORY_BUS_LEN_WIDTH-1:0] m_memory_awlen,
    output logic [MEMORY_ID_WIDTH-1:0]      m_memory_awid,
    output logic [2:0]                      m_memory_awsize,
    output logic [1:0]                      m_memory_awburst,
    output logic [1:0]                      m_memory_awlock,
    output logic [3:0]                      m_memory_awcache,
    output logic [2:0]                      m_memory_awprot,
    output logic [3:0]                      m_memory_awqos,
    output logic                            m_memory_wvalid,
    input  logic                            m_memory_wready,
    output logic [MEMORY_DATA_WIDTH-1:0]    m_memory_wdata,
    output logic [MEMORY_DATA_WIDTH/8-1:0]  m_memory_wstrb,
    output logic                            m_memory_wlast,
    output logic [MEMORY_ID_WIDTH-1:0]      m_memory_wid,
    input  logic                            m_memory_bvalid,
    output logic                            m_memory_bready,
    input  logic [1:0]                      m_memory_bresp,
    input  logic [MEMORY_ID_WIDTH-1:0]      m_memory_bid
);

    localparam int IDX_W = $clog2(MAX_BURST);
    localparam int NB_W  = 10;               // 4 KB / 8 bytes = 512 beats max room
    localparam int BL_W  = 29;               // Length[31:3]

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
    } state_t;

    state_t                         state, state_next;
    logic [MEMORY_ADDR_WIDTH-1:0]   src, dst;
    logic [BL_W-1:0]                beats_left;
    logic [IDX_W-1:0]               idx;
    logic                           rd_err;   // an earlier beat of this read burst had rresp != 0
    logic                           error_q;
    logic [NB_W-1:0]                nb, src_room, dst_room;
    logic [MEMORY_DATA_WIDTH-1:0]   beat_buf [MAX_BURST];
    logic                           last_wbeat;

    // Burst size: limited by remaining work, buffer depth, and the distance of
    // both src and dst to their next 4 KB page. The registers it depends on only
    // change in WR_RESP, so arlen/awlen stay stable across the handshakes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned -- that is what keeps latches from being inferred.
        src_room = 10'd512 - {1'b0, src[11:3]};
        dst_room = 10'd512 - {1'b0, dst[11:3]};
        nb       = NB_W'(MAX_BURST);
        if (src_room < nb) nb = src_room;
        if (dst_room < nb) nb = dst_room;
        if (beats_left < BL_W'(nb)) nb = beats_left[NB_W-1:0];
    end

    assign last_wbeat = (NB_W'(idx) == nb - NB_W'(1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next       = state;
        Busy             = (state != S_IDLE);
        Done             = 1'b0;
        m_memory_arvalid = 1'b0;
        m_memory_rready  = 1'b0;
        m_memory_awvalid = 1'b0;
        m_memory_wvalid  = 1'b0;
        m_memory_wlast   = 1'b0;
        m_memory_bready  = 1'b0;
        unique case (state)
            S_IDLE:
                if (Go) state_next = (Length[31:3] == '0) ? S_DONE : S_RD_ADDR;
            S_RD_ADDR: begin
                m_memory_arvalid = 1'b1;
                if (m_memory_arready) state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                m_memory_rready = 1'b1;
                if (m_memory_rvalid && m_memory_rlast)
                    state_next = (rd_err || m_memory_rresp != 2'b00) ? S_DONE : S_WR_ADDR;
            end
            S_WR_ADDR: begin
                m_memory_awvalid = 1'b1;
                if (m_memory_awready) state_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                m_memory_wvalid = 1'b1;
                m_memory_wlast  = last_wbeat;
                if (m_memory_wready && last_wbeat) state_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                m_memory_bready = 1'b1;
                if (m_memory_bvalid) begin
                    if (m_memory_bresp != 2'b00 || beats_left == BL_W'(nb)) state_next = S_DONE;
                    else                                                     state_next = S_RD_ADDR;
                end
            end
            S_DONE: begin
                Done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            src        <= '0;
            dst        <= '0;
            beats_left <= '0;
            idx        <= '0;
            rd_err     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE:
                    if (Go) begin
                        src        <= MEMORY_ADDR_WIDTH'({Src_addr[29:1], 3'b000});
                        dst        <= MEMORY_ADDR_WIDTH'({Dst_addr[29:1], 3'b000});
                        beats_left <= Length[31:3];
                        error_q    <= 1'b0;
                    end
                S_RD_ADDR: begin
                    idx    <= '0;
                    rd_err <= 1'b0;
                end
                S_RD_DATA:
                    if (m_memory_rvalid) begin
                        idx <= idx + 1'b1;
                        if (m_memory_rresp != 2'b00) rd_err <= 1'b1;
                        if (m_memory_rlast && (rd_err || m_memory_rresp != 2'b00)) error_q <= 1'b1;
                    end
                S_WR_ADDR: idx <= '0;
                S_WR_DATA:
                    if (m_memory_wready) idx <= idx + 1'b1;
                S_WR_RESP:
                    if (m_memory_bvalid) begin
                        if (m_memory_bresp != 2'b00) begin
                            error_q <= 1'b1;
                        end else begin
                            src        <= src + MEMORY_ADDR_WIDTH'({nb, 3'b000});
                            dst        <= dst + MEMORY_ADDR_WIDTH'({nb, 3'b000});
                            beats_left <= beats_left - BL_W'(nb);
                        end
                    end
                default: ;
            endcase
        end
    end

    // NOTE: the beat buffer is deliberately not reset; every entry is written by
    // the read burst before the write burst reads it, so reset would only cost area.
    always_ff @(posedge Clk) begin
        if (state == S_RD_DATA && m_memory_rvalid) beat_buf[idx] <= m_memory_rdata;
    end

    assign Error            = error_q;
    assign m_memory_araddr  = src;
    assign m_memory_awaddr  = dst;
    assign m_memory_arlen   = MEMORY_BUS_LEN_WIDTH'(nb - NB_W'(1));
    assign m_memory_awlen   = MEMORY_BUS_LEN_WIDTH'(nb - NB_W'(1));
    assign m_memory_wdata   = beat_buf[idx];
    assign m_memory_wstrb   = '1;
    assign m_memory_arid    = MEMORY_ID_WIDTH'(AXI_ID);
    assign m_memory_awid    = MEMORY_ID_WIDTH'(AXI_ID);
    assign m_memory_wid     = MEMORY_ID_WIDTH'(AXI_ID);
    assign m_memory_arsize  = 3'b011;
    assign m_memory_awsize  = 3'b011;
    assign m_memory_arburst = 2'b01;
    assign m_memory_awburst = 2'b01;
    assign m_memory_arlock  = 2'b00;
    assign m_memory_awlock  = 2'b00;
    assign m_memory_arcache = 4'b0011;
    assign m_memory_awcache = 4'b0011;
    assign m_memory_arprot  = 3'b000;
    assign m_memory_awprot  = 3'b000;
    assign m_memory_arqos   = 4'b0000;
    assign m_memory_awqos   = 4'b0000;

    // IDs are ignored (single outstanding transaction); alignment bits are dropped.
    logic unused_inputs;
    assign unused_inputs = ^{m_memory_rid, m_memory_bid, Src_addr[0], Dst_addr[0], Length[2:0]};

endmodule

// File: tb/tb_soc_miner_dma.sv
// Self-checking bench for soc_miner_dma: randomized AXI slave with a memory
// model, a transaction-level reference that plans the expected bursts, and a
// monitor that pops expected AR/AW/W/Done items as the DUT presents them.

module tb_soc_miner_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [29:0] src_w = '0, dst_w = '0;
    logic [31:0] length = '0;
    logic        busy, done, error;

    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arlen, awlen, arcache, awcache, arqos, awqos;
    logic [5:0]  arid, awid, wid, rid, bid;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [63:0] rdata, wdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [7:0]  wstrb;

    soc_miner_dma dut (
        .Clk(clk), .Rst_n(rst_n), .Go(go), .Src_addr(src_w), .Dst_addr(dst_w), .Length(length),
        .Busy(busy), .Done(done), .Error(error),
        .m_memory_arvalid(arvalid), .m_memory_arready(arready), .m_memory_araddr(araddr),
        .m_memory_arlen(arlen), .m_memory_arid(arid), .m_memory_arsize(arsize),
        .m_memory_arburst(arburst), .m_memory_arlock(arlock), .m_memory_arcache(arcache),
        .m_memory_arprot(arprot), .m_memory_arqos(arqos),
        .m_memory_rvalid(rvalid), .m_memory_rready(rready), .m_memory_rdata(rdata),
        .m_memory_rlast(rlast), .m_memory_rresp(rresp), .m_memory_rid(rid),
        .m_memory_awvalid(awvalid), .m_memory_awready(awready), .m_memory_awaddr(awaddr),
        .m_memory_awlen(awlen), .m_memory_awid(awid), .m_memory_awsize(awsize),
        .m_memory_awburst(awburst), .m_memory_awlock(awlock), .m_memory_awcache(awcache),
        .m_memory_awprot(awprot), .m_memory_awqos(awqos),
        .m_memory_wvalid(wvalid), .m_memory_wready(wready), .m_memory_wdata(wdata),
        .m_memory_wstrb(wstrb), .m_memory_wlast(wlast), .m_memory_wid(wid),
        .m_memory_bvalid(bvalid), .m_memory_bready(bready), .m_memory_bresp(bresp),
        .m_memory_bid(bid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [3:0] len; } ax_t;
    typedef struct { logic [63:0] data; logic last; } w_t;

    ax_t exp_ar[$];
    ax_t exp_aw[$];
    w_t  exp_w[$];
    bit  exp_done[$];

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int done_base = 0;

    logic [63:0] mem [int unsigned];

    // slave state
    bit          rd_act, r_hold, wr_act, b_pend, b_hold, hold_wready;
    logic [31:0] rd_addr, wr_addr;
    int          rd_len, rd_cnt, wr_cnt, ar_seen, aw_seen, cur_r_burst, cur_w_burst, r_beats;
    int          inj_r_burst = -1, inj_r_beat = 0, inj_b_burst = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        int unsigned k = a >> 3;
        if (mem.exists(k)) return mem[k];
        return {~a, a ^ 32'h5A5A_1234};
    endfunction

    // Reference: plan the copy as a list of bursts from plain arithmetic.
    task automatic plan(input logic [31:0] s0, input logic [31:0] d0, input logic [31:0] len);
        int beats, nb, sr, dr, k;
        logic [31:0] s, d;
        bit err;
        beats = int'(len >> 3);
        s = s0; d = d0; k = 0; err = 0;
        while (beats > 0) begin
            sr = (4096 - int'(s % 4096)) / 8;
            dr = (4096 - int'(d % 4096)) / 8;
            nb = 16;
            if (sr < nb) nb = sr;
            if (dr < nb) nb = dr;
            if (beats < nb) nb = beats;
            exp_ar.push_back('{s, 4'(nb - 1)});
            if (k == inj_r_burst) begin err = 1; break; end
            exp_aw.push_back('{d, 4'(nb - 1)});
            for (int i = 0; i < nb; i++) exp_w.push_back('{mem_rd(s + 32'(i * 8)), i == nb - 1});
            if (k == inj_b_burst) begin err = 1; break; end
            s += 32'(nb * 8); d += 32'(nb * 8); beats -= nb; k++;
        end
        exp_done.push_back(err);
    endtask

    // AXI slave: drives on negedge, evaluates handshakes 2 time units later.
    initial begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = '0; rlast = 0; rresp = 0; rid = '0; bresp = 0; bid = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_act = 0; r_hold = 0; wr_act = 0; b_pend = 0; b_hold = 0;
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
                continue;
            end
            arready = ($urandom_range(0, 3) != 0);
            awready = ($urandom_range(0, 3) != 0);
            wready  = hold_wready ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (!r_hold) begin
                if (rd_act && $urandom_range(0, 2) != 0) begin
                    rvalid = 1;
                    rdata  = mem_rd(rd_addr + 32'(rd_cnt * 8));
                    rlast  = (rd_cnt == rd_len - 1);
                    rresp  = (cur_r_burst == inj_r_burst && rd_cnt == inj_r_beat) ? 2'b10 : 2'b00;
                    r_hold = 1;
                end else rvalid = 0;
            end
            if (!b_hold) begin
                if (b_pend && $urandom_range(0, 2) != 0) begin
                    bvalid = 1;
                    bresp  = (cur_w_burst == inj_b_burst) ? 2'b10 : 2'b00;
                    b_hold = 1;
                end else bvalid = 0;
            end
            #2;
            if (!rst_n) continue;
            if (arvalid && arready) begin
                rd_act = 1; rd_addr = araddr; rd_len = int'(arlen) + 1; rd_cnt = 0;
                cur_r_burst = ar_seen; ar_seen++;
            end
            if (rvalid && rready) begin
                rd_cnt++; r_beats++; r_hold = 0;
                if (rlast) rd_act = 0;
            end
            if (awvalid && awready) begin
                wr_act = 1; wr_addr = awaddr; wr_cnt = 0; cur_w_burst = aw_seen; aw_seen++;
            end
            if (wvalid && wready) begin
                mem[(wr_addr + 32'(wr_cnt * 8)) >> 3] = wdata;
                wr_cnt++;
                if (wlast) begin wr_act = 0; b_pend = 1; end
            end
            if (bvalid && bready) begin b_pend = 0; b_hold = 0; end
        end
    end

    // Monitor / scoreboard
    initial begin
        ax_t a;
        w_t  w;
        bit  e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) continue;
            if (arvalid && arready) begin
                check("ar_expected", 64'(exp_ar.size() != 0), 1);
                if (exp_ar.size() != 0) begin
                    a = exp_ar.pop_front();
                    check("araddr", araddr, a.addr);
                    check("arlen", arlen, a.len);
                    check("ar_in_4k_page", 64'((araddr % 4096) + (arlen + 1) * 8 <= 4096), 1);
                end
            end
            if (awvalid && awready) begin
                check("aw_expected", 64'(exp_aw.size() != 0), 1);
                if (exp_aw.size() != 0) begin
                    a = exp_aw.pop_front();
                    check("awaddr", awaddr, a.addr);
                    check("awlen", awlen, a.len);
                end
            end
            if (wvalid && wready) begin
                check("w_expected", 64'(exp_w.size() != 0), 1);
                if (exp_w.size() != 0) begin
                    w = exp_w.pop_front();
                    check("wdata", wdata, w.data);
                    check("wlast", wlast, w.last);
                end
            end
            if (awvalid && wvalid) check("aw_w_overlap", 1, 0);
            if (done) begin
                done_cnt++;
                check("done_expected", 64'(exp_done.size() != 0), 1);
                if (exp_done.size() != 0) begin
                    e = exp_done.pop_front();
                    check("error_at_done", error, e);
                    check("busy_at_done", busy, 1);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 3000 && busy; n++) @(negedge clk);
        check("idle_reached", busy, 0);
    endtask

    // Returns after the negedge that ends the Go pulse (i.e. at the start of cycle 1).
    task automatic start_copy(input logic [31:0] sb, input logic [31:0] db, input logic [31:0] len,
                              input int rb, input int rbeat, input int bb);
        wait_idle();
        inj_r_burst = rb; inj_r_beat = rbeat; inj_b_burst = bb;
        ar_seen = 0; aw_seen = 0; r_beats = 0;
        done_base = done_cnt;
        plan(sb, db, len);
        @(negedge clk);
        go = 1; src_w = sb[31:2]; dst_w = db[31:2]; length = len;
        @(negedge clk);
        go = 0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 5000 && done_cnt == done_base; n++) @(negedge clk);
        #3;
        check("done_pulses", done_cnt - done_base, 1);
    endtask

    task automatic post_check(input logic [31:0] sb, input logic [31:0] db, input logic [31:0] len,
                              input bit exp_err);
        int mism;
        check("ar_left", exp_ar.size(), 0);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
        check("done_left", exp_done.size(), 0);
        check("error_sticky", error, exp_err);
        if (!exp_err) begin
            mism = 0;
            for (int i = 0; i < int'(len >> 3); i++)
                if (mem_rd(db + 32'(i * 8)) !== mem_rd(sb + 32'(i * 8))) mism++;
            check("dst_mem_mismatches", mism, 0);
        end
    endtask

    task automatic copy(input logic [31:0] sb, input logic [31:0] db, input logic [31:0] len,
                        input int rb, input int bb);
        start_copy(sb, db, len, rb, 0, bb);
        wait_done();
        post_check(sb, db, len, (rb >= 0 || bb >= 0) && len >= 8);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] sb, db, len;
        int rb, bb;
        hold_wready = 0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_status", {busy, done, error}, 3'b000);
        check("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        check("ar_consts", {arsize, arburst, arlock, arcache, arprot, arqos, arid},
              {3'b011, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 6'd0});
        check("aw_consts", {awsize, awburst, awlock, awcache, awprot, awqos, awid, wid, wstrb},
              {3'b011, 2'b01, 2'b00, 4'b0011, 3'b000, 4'b0000, 6'd0, 6'd0, 8'hFF});
        @(negedge clk);
        rst_n = 1;

        // 1: single 8-beat burst, cycle-1 timing
        start_copy(32'h400, 32'h1000, 64, -1, 0, -1);
        #2;
        check("cycle1_busy", busy, 1);
        check("cycle1_arvalid", arvalid, 1);
        wait_done();
        post_check(32'h400, 32'h1000, 64, 0);

        // 2: 25 beats -> 16 + 9
        copy(32'h10000, 32'h20000, 200, -1, -1);

        // 3: source 0xFC0, split at the 4 KB page
        copy(32'hFC0, 32'h8000, 128, -1, -1);

        // 4: length below one beat
        start_copy(32'h3000, 32'h4000, 5, -1, 0, -1);
        #2;
        check("short_cycle1", {done, busy, arvalid, awvalid, wvalid}, 5'b11000);
        @(negedge clk);
        #2;
        check("short_cycle2", {done, busy, arvalid, awvalid, wvalid}, 5'b00000);
        wait_done();
        post_check(32'h3000, 32'h4000, 5, 0);

        // 5: read error on beat 3 of 8
        start_copy(32'h30000, 32'h38000, 64, 0, 3, -1);
        wait_done();
        post_check(32'h30000, 32'h38000, 64, 1);
        check("err_r_beats", r_beats, 8);

        // 6: async reset during stalled write data; Go clears Error first
        hold_wready = 1;
        start_copy(32'h50000, 32'h60000, 64, -1, 0, -1);
        #2;
        check("go_clears_error", error, 0);
        for (int n = 0; n < 1000 && !wvalid; n++) begin @(negedge clk); #2; end
        check("wvalid_seen", wvalid, 1);
        #1 rst_n = 0;
        #1;
        check("async_reset", {wvalid, busy, arvalid, awvalid}, 4'b0000);
        exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_done.delete();
        hold_wready = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        copy(32'h50000, 32'h60000, 64, -1, -1);

        // randomized copies, some with injected read/write errors
        for (int i = 0; i < 8; i++) begin
            sb  = 32'h100000 + 32'(i) * 32'h20000 + 32'($urandom_range(0, 511) * 8);
            db  = 32'h100000 + 32'(i) * 32'h20000 + 32'h10000 + 32'($urandom_range(0, 511) * 8);
            len = 32'($urandom_range(0, 600));
            rb  = ($urandom_range(0, 3) == 0) ? 0 : -1;
            bb  = (rb < 0 && $urandom_range(0, 3) == 0) ? 0 : -1;
            copy(sb, db, len, rb, bb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_miner_dma.md
# soc_miner_dma

Copy engine that sequences the AXI4 master memory port of soc_miner. A one-cycle Go pulse from the register block starts a copy of Length bytes from the source to the destination address in DRAM. The copy runs as store-and-forward bursts: one read burst fills an internal buffer, then one write burst drains it, repeated until Length is exhausted. Done, Busy and Error are reported back to the register block.

## Interface
- MEMORY_DATA_WIDTH, 64: beat width. Only 64 is supported.
- MEMORY_ADDR_WIDTH, 32: AXI byte-address width.
- MEMORY_BUS_LEN_WIDTH, 4: ax*len width.
- MEMORY_ID_WIDTH, 6: ID width.
- MAX_BURST, 16: maximum beats per burst and buffer depth. Must be ≤ 2^MEMORY_BUS_LEN_WIDTH.
- AXI_ID, 0: constant value driven on arid, awid and wid.

Ports:
- Clk  in  1  clock. The block uses this single clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- Go  in  1  start pulse. Ignored while Busy=1.
- Src_addr  in  30  source word address. Byte address = {Src_addr,2'b00}; bit 0 is forced to 0 (8-byte alignment).
- Dst_addr  in  30  destination word address, same rule as Src_addr.
- Length  in  32  byte count. Bits [2:0] are ignored.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse at the end of a copy.
- Error  out  1  sticky. Cleared by an accepted Go.
- m_memory_ar*: arvalid out 1, arready in 1, araddr out ADDR, arlen out LEN, arid out ID, arsize out 3, arburst out 2, arlock out 2, arcache out 4, arprot out 3, arqos out 4.
- m_memory_r*: rvalid in 1, rready out 1, rdata in 64, rlast in 1, rresp in 2, rid in ID.
- m_memory_aw*: same set as ar*, with aw prefix and identical widths and directions.
- m_memory_w*: wvalid out 1, wready in 1, wdata out 64, wstrb out 8, wlast out 1, wid out ID.
- m_memory_b*: bvalid in 1, bready out 1, bresp in 2, bid in ID.

## Operation
- Constant outputs:
  - ax*size = 3'b011.
  - ax*burst = 2'b01 (INCR).
  - ax*lock = 0.
  - ax*cache = 4'b0011.
  - ax*prot = 0.
  - ax*qos = 0.
  - wstrb = 8'hFF.
- Go accepted in IDLE:
  - Latch src, dst and beats_left = Length[31:3].
  - Clear Error.
  - If beats_left = 0, go to DONE; otherwise go to RD_ADDR.
- Burst size, computed in RD_ADDR: nb = min(beats_left, MAX_BURST, beats to the next 4 KB boundary of src, beats to the next 4 KB boundary of dst). This is always ≥1. arlen = awlen = nb-1.
- States and transitions:
  - RD_ADDR: arvalid=1. On arready, go to RD_DATA.
  - RD_DATA: rready=1. Each rvalid beat is stored into buf[idx] and idx increments.
    - On the rlast beat, if any beat of the burst had rresp≠0, go to DONE and set Error.
    - Otherwise go to WR_ADDR.
  - WR_ADDR: awvalid=1. On awready, go to WR_DATA with idx=0.
  - WR_DATA: wvalid=1, wdata=buf[idx], wlast=(idx==nb-1). On wready, idx increments. The last beat goes to WR_RESP.
  - WR_RESP: bready=1. On bvalid:
    - If bresp≠0, set Error and go to DONE.
    - Otherwise src += nb*8, dst += nb*8, beats_left -= nb. If beats_left = 0, go to DONE; otherwise go to RD_ADDR.
  - DONE: Done=1 for one cycle, then go to IDLE.
- Address arithmetic: 32 bits, wraps modulo 2^32. 4 KB splitting guarantees that no burst crosses a boundary.
- rid and bid are ignored: there is a single outstanding transaction.
- rlast is authoritative. A beat count that disagrees with arlen is not checked.

## Timing
- Reset values:
  - All valid and ready outputs are 0.
  - Busy=0, Done=0, Error=0.
  - Addresses and lengths are 0.
  - State is IDLE.
- Reset is asynchronous mid-operation. It drops every valid immediately, and the outstanding AXI transaction is abandoned.
- Go sampled at edge 0 causes Busy=1 and arvalid=1 in cycle 1. Length 0 causes Done=1 in cycle 1 and Busy=0 in cycle 2.
- Handshake rules:
  - All valids are registered.
  - Each valid is held with stable payload until the matching ready is seen.
  - A valid never depends combinationally on the ready.
- Beat rates:
  - rready is continuous in RD_DATA, giving one beat per cycle when rvalid=1.
  - wvalid is continuous in WR_DATA; the next beat is presented in the cycle after a wready.
- Ordering: AW and W of one burst are not overlapped. awvalid goes low before wvalid rises.
- With an ideal zero-wait slave, a burst of nb beats costs nb+nb+5 cycles.
- Go while Busy=1 has no effect.
- Done and a new Go in the same cycle: Go is ignored, because the state is not yet IDLE.

## Test plan
1. Length=64, Src_addr=0x100, Dst_addr=0x400, ideal slave -> one AR (araddr 0x400, arlen 7), then one AW (awaddr 0x1000, awlen 7); 8 W beats equal the R data, wlast on the 8th beat; Done pulses once; Error=0.
2. Length=200 -> two bursts: arlen 15 then arlen 8; the second araddr is the first +128; destination memory matches the source for 25 beats.
3. Source byte address 0xFC0, Length=128 -> bursts of 8 and 8 beats; no araddr range crosses 0x1000.
4. Length=5 (below 8 bytes) -> Done in cycle 1, Busy=0 in cycle 2, no valid asserted at any time.
5. rresp=2'b10 on beat 3 of 8 -> all 8 beats accepted, awvalid never asserted, Done=1, Error=1; the next Go clears Error.
6. Rst_n low during WR_DATA with wready held at 0 -> wvalid and Busy go to 0 without waiting for a clock edge; after release, a new Go runs a full copy correctly.
